// File: rtl/dmem_pkg.sv
// dmem_pkg: size encodings, FSM states and load lane extraction for dmem_stage
package dmem_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    typedef enum logic [1:0] {IDLE = S_IDLE, WAIT = S_WAIT, RESP = S_RESP} dmem_state_t;
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] addr_lo,
                                                 input logic [1:0] size, input logic sign_ext);
        logic [31:0] sh;
        sh = word >> {addr_lo, 3'b000};
        return size == SZ_BYTE ? {{24{sign_ext & sh[7]}}, sh[7:0]} :
               size == SZ_HALF ? {{16{sign_ext & sh[15]}}, sh[15:0]} : word;
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the EX-side requester and dmem_stage
interface dmem_if;
    logic        req_valid, req_ready, mem_r_en, mem_w_en, sign_ext, rsp_valid, acc_err;
    logic [1:0]  size;
    logic [31:0] address, st_val, rd_data;
    modport master(output req_valid, mem_r_en, mem_w_en, size, sign_ext, address, st_val,
                   input req_ready, rsp_valid, rd_data, acc_err);
    modport slave(input req_valid, mem_r_en, mem_w_en, size, sign_ext, address, st_val,
                  output req_ready, rsp_valid, rd_data, acc_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTHx32 word store with byte write enables and a registered read port
module dmem_array #(
    parameter int DEPTH      = 64,
    parameter bit INIT_INDEX = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] idx,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);
    logic [31:0] mem [DEPTH];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_INDEX ? 32'(i) : '0;
            rdata <= '0;
        end else begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            if (re) rdata <= mem[idx];
        end
endmodule

// File: rtl/dmem_stage.sv
// dmem_stage: EX->WB data-memory stage with wait states, byte/half/word access and legality check
module dmem_stage import dmem_pkg::*; #(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter int          WAIT_STATES = 1,
    parameter bit          INIT_INDEX  = 1
) (
    input logic   clk,
    input logic   rst_n,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    dmem_state_t state;
    logic [1:0] cnt, l_sz, s_sz;
    logic l_r, l_w, l_sx, l_err, s_r, s_w, s_err, in_err, accept, go;
    logic [AW+1:0] l_addr, s_addr;
    logic [31:0] l_st, s_st, off, rdata, wdata;
    logic [3:0] be;
    assign bus.req_ready = rst_n && state != WAIT;
    assign accept = bus.req_valid && bus.req_ready;
    assign off = bus.address - BASE_ADDR;
    assign in_err = bus.size == 2'b11 || (bus.size == SZ_HALF && bus.address[0]) ||
                    (bus.size == SZ_WORD && bus.address[1:0] != 2'b00) ||
                    bus.address < BASE_ADDR || off >= 32'(4*DEPTH) || (bus.mem_r_en && bus.mem_w_en);
    // Without wait states the access edge is the accept edge, so it uses the live request
    assign go = WAIT_STATES == 0 ? accept : state == WAIT && cnt == 2'd0;
    assign s_r = WAIT_STATES == 0 ? bus.mem_r_en : l_r;
    assign s_w = WAIT_STATES == 0 ? bus.mem_w_en : l_w;
    assign s_err = WAIT_STATES == 0 ? in_err : l_err;
    assign s_sz = WAIT_STATES == 0 ? bus.size : l_sz;
    assign s_addr = WAIT_STATES == 0 ? bus.address[AW+1:0] : l_addr;
    assign s_st = WAIT_STATES == 0 ? bus.st_val : l_st;
    assign be = !go || !s_w || s_err ? 4'h0 :
                s_sz == SZ_BYTE ? 4'b0001 << s_addr[1:0] :
                s_sz == SZ_HALF ? 4'b0011 << {s_addr[1], 1'b0} : 4'hF;
    assign wdata = s_sz == SZ_BYTE ? {4{s_st[7:0]}} : s_sz == SZ_HALF ? {2{s_st[15:0]}} : s_st;
    dmem_array #(.DEPTH(DEPTH), .INIT_INDEX(INIT_INDEX)) u_array (
        .clk(clk), .rst_n(rst_n), .idx(s_addr[AW+1:2]), .be(be), .wdata(wdata),
        .re(go && s_r && !s_err), .rdata(rdata)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            l_r <= 1'b0;
            l_w <= 1'b0;
            l_sx <= 1'b0;
            l_err <= 1'b0;
            l_sz <= '0;
            l_addr <= '0;
            l_st <= '0;
        end else begin
            if (accept) begin
                l_r <= bus.mem_r_en;
                l_w <= bus.mem_w_en;
                l_sx <= bus.sign_ext;
                l_err <= in_err;
                l_sz <= bus.size;
                l_addr <= bus.address[AW+1:0];
                l_st <= bus.st_val;
                cnt <= WAIT_STATES == 0 ? 2'd0 : 2'(WAIT_STATES - 1);
            end else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
            state <= accept ? (WAIT_STATES == 0 ? RESP : WAIT) :
                     state == WAIT ? (cnt == 2'd0 ? RESP : WAIT) : IDLE;
        end
    assign bus.rsp_valid = state == RESP;
    assign bus.acc_err = state == RESP && l_err;
    assign bus.rd_data = state == RESP && l_r && !l_err ? lane_extract(rdata, l_addr[1:0], l_sz, l_sx) : '0;
endmodule

// File: doc/dmem_stage.md
# dmem_stage

Parametrised data-memory pipeline stage sitting between EX and WB. It serves loads and stores of byte, halfword and word size against a word-organised array mapped at a configurable base address. Each access takes a configurable number of wait states under a valid/ready handshake, and illegal accesses are flagged instead of corrupting memory. It is the successor to the fixed 64-word, word-only, single-cycle data memory.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; a power of two, at least 4.
- `BASE_ADDR`, 32'h0000_0400: byte address of word 0; aligned to 4*DEPTH.
- `WAIT_STATES`, 1: extra cycles per access, 0..3.
- `INIT_INDEX`, 1: 1 means reset loads word i with i; 0 means reset loads 0.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: stage can accept a request this cycle.
- `mem_r_en`, in, 1: load request.
- `mem_w_en`, in, 1: store request.
- `size`, in, 2: 00 byte, 01 half, 10 word, 11 illegal.
- `sign_ext`, in, 1: loads only; 1 sign-extends, 0 zero-extends.
- `address`, in, 32: byte address.
- `st_val`, in, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rd_data`, out, 32: load result; valid only while `rsp_valid` is high.
- `acc_err`, out, 1: completed access was illegal; valid only while `rsp_valid` is high.

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` is high in IDLE and RESP, low in WAIT.
- **Accept:** a request is accepted when `req_valid` and `req_ready` are both high. All inputs are latched on that edge.
- **Next state after accept:** WAIT if `WAIT_STATES` > 0, otherwise RESP directly.
- **WAIT:** a counter loads `WAIT_STATES`-1 on accept and decrements each cycle. The FSM moves to RESP on the edge where the counter is 0.
- **Access edge:** the memory access happens on the edge that enters RESP.
  - A store writes only its byte lanes, little-endian. A byte uses lane `address[1:0]`; a half uses lanes {a1,0},{a1,1}.
  - A load registers the aligned lane and extends it to 32 bits per `sign_ext`.
- **RESP:** `rsp_valid` is 1 for exactly one cycle. If a new request is accepted in RESP, the next state is WAIT or RESP; otherwise it is IDLE.
- **Back-to-back:** with `WAIT_STATES`=0 the stage sustains one access per cycle.
- **Illegal access** (`acc_err`=1, memory unchanged, `rd_data`=0). Any one of:
  - `size`=11;
  - half at an odd address;
  - word with `address[1:0]`≠0;
  - `address` < `BASE_ADDR`;
  - `address` ≥ `BASE_ADDR`+4*`DEPTH`;
  - `mem_r_en` and `mem_w_en` both set.
- **NOP** (neither enable set): completes normally with `rsp_valid`, `acc_err`=0, `rd_data`=0.
- **Store response:** a store completes with `rd_data`=0.
- **Word index:** (`address`-`BASE_ADDR`)>>2, truncated to log2(`DEPTH`) bits after the range check passes.
- **Read/write ordering:** a load immediately after a store to the same word returns the new data, because accesses are serialised.

## Timing
- Reset values: `req_ready`=0 while `rst_n` is low and 1 from the first cycle after release. `rsp_valid`=0, `rd_data`=0, `acc_err`=0. State is IDLE and the counter is 0. Memory is initialised per `INIT_INDEX`.
- Latency: `rsp_valid` is high in the cycle after the (`WAIT_STATES`+1)-th rising edge counted from the accept edge, with the accept edge counted as the first.
- Reset asserted mid-access: the pending access is dropped, any write not yet committed never happens, and outputs go to reset values immediately (asynchronously).
- `req_valid` is ignored while `req_ready`=0. The requester holds the request until it is accepted.

## Structure
- Package `dmem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum `dmem_state_t`;
  - function `lane_extract(word, addr_lo, size, sign_ext)`.
- Sub-module `dmem_array`:
  - DEPTH×32 storage with a 4-bit byte-write-enable;
  - registered read port;
  - asynchronous reset initialisation per `INIT_INDEX`.
- The top level holds the FSM, the wait counter, the legality check and the lane merge/extract.

## Test plan
- Reset, defaults (`WAIT_STATES`=1): word load at 0x408 with `sign_ext`=0 → `rsp_valid` high 2 cycles after accept, `rd_data`=0x0000_0002, `acc_err`=0.
- Byte store 0xAB to 0x405, then a word load from 0x404 → `rd_data`=0x0000_AB01.
- Half store 0x8001 to 0x40A, then a half load from 0x40A with `sign_ext`=1 → 0xFFFF_8001; with `sign_ext`=0 → 0x0000_8001.
- Each of these → `acc_err`=1, memory unchanged (verified by re-reading word 0x400 = 0):
  - word store to 0x401;
  - store to 0x3FC;
  - store to 0x500 (DEPTH=64);
  - `size`=11;
  - both enables set.
- `WAIT_STATES`=0 stream of 8 consecutive word loads from 0x400..0x41C → `req_ready` stays 1 and `rsp_valid` is high 8 consecutive cycles, returning 0..7. `WAIT_STATES`=3 → `req_ready` is low for 3 cycles per access.
- Store issued with `WAIT_STATES`=2, `rst_n` pulsed low during WAIT → no `rsp_valid`, and the target word reads back its `INIT_INDEX` value after reset.
